// File: rtl/idu_pkg.sv
// rtl/idu_pkg.sv - shared opcodes, ALU encoding, masks, state enum and decode bundle
package idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  localparam logic [7:0] WMASK_NONE = 8'h00;
  localparam logic [7:0] WMASK_B    = 8'h01;
  localparam logic [7:0] WMASK_H    = 8'h03;
  localparam logic [7:0] WMASK_W    = 8'h0F;
  localparam logic [7:0] WMASK_D    = 8'hFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    alu_op_e    alu_op;
    logic       need_imm;
    logic       reg_wen;
    logic       mem_ren;
    logic       mem_wen;
    logic       mem_unsigned;
    logic [7:0] wmask;
    logic       is_jal;
    logic       is_jalr;
    logic       is_branch;
    logic       is_auipc;
    logic       is_lui;
    logic       is_ebreak;
    logic [2:0] br_cond;
    logic       illegal;
  } dec_ctrl_t;

  // alt selects SUB/SRA; the caller decides when bit 30 is meaningful
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// rtl/idu_decode_comb.sv - combinational RV64I instruction-to-bundle decoder
module idu_decode_comb
  import idu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output dec_ctrl_t       ctrl,
  output logic [XLEN-1:0] imm
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            legal;
  dec_ctrl_t       raw;
  logic [XLEN-1:0] raw_imm;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'h000};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    raw     = '0;
    raw_imm = '0;
    legal   = 1'b0;
    raw.rd  = inst[11:7];
    raw.rs1 = inst[19:15];
    raw.rs2 = inst[24:20];
    raw.alu_op = ALU_ADD;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; raw.is_lui = 1'b1; raw.alu_op = ALU_PASSB;
        raw.need_imm = 1'b1; raw.reg_wen = 1'b1; raw_imm = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1; raw.is_auipc = 1'b1;
        raw.need_imm = 1'b1; raw.reg_wen = 1'b1; raw_imm = imm_u;
      end
      OPC_JAL: begin
        legal = 1'b1; raw.is_jal = 1'b1; raw.reg_wen = 1'b1; raw_imm = imm_j;
      end
      OPC_JALR: begin
        legal = (funct3 == 3'b000); raw.is_jalr = 1'b1;
        raw.need_imm = 1'b1; raw.reg_wen = 1'b1; raw_imm = imm_i;
      end
      OPC_BRANCH: begin
        legal = (funct3[2:1] != 2'b01); raw.is_branch = 1'b1;
        raw.alu_op = ALU_SUB; raw.br_cond = funct3; raw_imm = imm_b;
      end
      OPC_LOAD: begin
        legal = (funct3 != 3'b111); raw.mem_ren = 1'b1; raw.mem_unsigned = funct3[2];
        raw.need_imm = 1'b1; raw.reg_wen = 1'b1; raw_imm = imm_i;
      end
      OPC_STORE: begin
        legal = !funct3[2]; raw.mem_wen = 1'b1; raw.need_imm = 1'b1; raw_imm = imm_s;
        case (funct3[1:0])
          2'b00:   raw.wmask = WMASK_B;
          2'b01:   raw.wmask = WMASK_H;
          2'b10:   raw.wmask = WMASK_W;
          default: raw.wmask = WMASK_D;
        endcase
      end
      OPC_OP_IMM: begin
        // Shift immediates carry a 6-bit shamt, so only inst[31:26] are funct bits
        case (funct3)
          3'b001:  legal = (inst[31:26] == 6'b000000);
          3'b101:  legal = (inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000);
          default: legal = 1'b1;
        endcase
        raw.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && inst[30]);
        raw.need_imm = 1'b1; raw.reg_wen = 1'b1; raw_imm = imm_i;
      end
      OPC_OP: begin
        legal = (inst[31:25] == 7'b0000000) ||
                ((inst[31:25] == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        raw.alu_op = alu_from_funct3(funct3, inst[30]);
        raw.reg_wen = 1'b1;
      end
      OPC_SYSTEM: begin
        legal = (inst == INST_EBREAK); raw.is_ebreak = 1'b1;
      end
      default: legal = (inst == 32'h00000000);
    endcase
  end

  always_comb begin
    ctrl = raw;
    imm  = raw_imm;
    if (!legal) begin
      ctrl         = '0;
      ctrl.rd      = inst[11:7];
      ctrl.rs1     = inst[19:15];
      ctrl.rs2     = inst[24:20];
      ctrl.alu_op  = ALU_ADD;
      ctrl.illegal = 1'b1;
      imm          = '0;
    end
    if (ctrl.rd == 5'd0) ctrl.reg_wen = 1'b0;
  end

endmodule

// File: rtl/idu_stage.sv
// rtl/idu_stage.sv - registered decode stage: instruction queue, output register, run/halt FSM
module idu_stage
  import idu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int PC_W     = 64,
  parameter int IQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_need_imm,
  output logic            out_reg_wen,
  output logic            out_mem_ren,
  output logic            out_mem_wen,
  output logic            out_mem_unsigned,
  output logic [7:0]      out_wmask,
  output logic            out_is_jal,
  output logic            out_is_jalr,
  output logic            out_is_branch,
  output logic            out_is_auipc,
  output logic            out_is_lui,
  output logic            out_is_ebreak,
  output logic [2:0]      out_br_cond,
  output logic            out_illegal,
  output logic            halted
);

  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = $clog2(IQ_DEPTH + 1);

  logic [31:0]      q_inst [IQ_DEPTH];
  logic [PC_W-1:0]  q_pc   [IQ_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  state_e           state, state_nxt;
  dec_ctrl_t        dec_ctrl, ctrl_q;
  logic [XLEN-1:0]  dec_imm, imm_q;
  logic [PC_W-1:0]  pc_q;
  logic             valid_q;

  logic push, load, fire_out, halt_evt;

  idu_decode_comb #(.XLEN(XLEN)) u_decode (
    .inst (q_inst[head]),
    .ctrl (dec_ctrl),
    .imm  (dec_imm)
  );

  assign fire_out = valid_q && out_ready;
  assign halt_evt = fire_out && (ctrl_q.is_ebreak || ctrl_q.illegal);
  assign in_ready = (count != CNT_W'(IQ_DEPTH)) && (state == ST_RUN) && !flush;
  assign push     = in_valid && in_ready;
  // The halting bundle's own handshake cycle must not refill the register
  assign load     = (count != '0) && (!valid_q || out_ready) && (state == ST_RUN) &&
                    !halt_evt && !flush;

  always_ff @(posedge clk) begin
    if (state == ST_RUN && push) begin
      q_inst[tail] <= in_inst;
      q_pc[tail]   <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (load) head <= head + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      ctrl_q  <= dec_ctrl;
      imm_q   <= dec_imm;
      pc_q    <= q_pc[head];
    end else if (fire_out) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (halt_evt) state_nxt = ST_HALT;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign halted           = (state == ST_HALT);
  assign out_valid        = valid_q;
  assign out_pc           = pc_q;
  assign out_imm          = imm_q;
  assign out_rd           = ctrl_q.rd;
  assign out_rs1          = ctrl_q.rs1;
  assign out_rs2          = ctrl_q.rs2;
  assign out_alu_op       = ctrl_q.alu_op;
  assign out_need_imm     = ctrl_q.need_imm;
  assign out_reg_wen      = ctrl_q.reg_wen;
  assign out_mem_ren      = ctrl_q.mem_ren;
  assign out_mem_wen      = ctrl_q.mem_wen;
  assign out_mem_unsigned = ctrl_q.mem_unsigned;
  assign out_wmask        = ctrl_q.wmask;
  assign out_is_jal       = ctrl_q.is_jal;
  assign out_is_jalr      = ctrl_q.is_jalr;
  assign out_is_branch    = ctrl_q.is_branch;
  assign out_is_auipc     = ctrl_q.is_auipc;
  assign out_is_lui       = ctrl_q.is_lui;
  assign out_is_ebreak    = ctrl_q.is_ebreak;
  assign out_br_cond      = ctrl_q.br_cond;
  assign out_illegal      = ctrl_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// tb/tb_idu_stage.sv - directed self-checking bench for idu_stage
module tb_idu_stage;
  import idu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [3:0]  out_alu_op;
  logic        out_need_imm, out_reg_wen, out_mem_ren, out_mem_wen, out_mem_unsigned;
  logic [7:0]  out_wmask;
  logic        out_is_jal, out_is_jalr, out_is_branch, out_is_auipc, out_is_lui, out_is_ebreak;
  logic [2:0]  out_br_cond;
  logic        out_illegal, halted;

  int passed = 0;
  int total  = 0;

  idu_stage #(.XLEN(64), .PC_W(64), .IQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_need_imm(out_need_imm), .out_reg_wen(out_reg_wen),
    .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen), .out_mem_unsigned(out_mem_unsigned),
    .out_wmask(out_wmask), .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr),
    .out_is_branch(out_is_branch), .out_is_auipc(out_is_auipc), .out_is_lui(out_is_lui),
    .out_is_ebreak(out_is_ebreak), .out_br_cond(out_br_cond), .out_illegal(out_illegal),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_store(input logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'd4, 7'b0100011};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0;
    step();
    rst = 1'b0;
  endtask

  // push one instruction and wait until its bundle sits in the output register
  task automatic issue(input logic [31:0] inst);
    in_inst = inst; in_pc = 64'h1000; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0h want 0", out_valid); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL reset_halted got %0h want 0", halted); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0h want 1", in_ready); else passed++;
    total++; if (out_imm !== 64'd0 || out_rd !== 5'd0 || out_wmask !== 8'd0 || out_pc !== 64'd0)
      $display("FAIL reset_fields got imm=%0h rd=%0d wmask=%0h pc=%0h want all 0", out_imm, out_rd, out_wmask, out_pc);
    else passed++;
  endtask

  task automatic test_addi();
    in_inst = 32'hFFF00093; in_pc = 64'h80000000; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL addi_latency_e0 got %0h want 0", out_valid); else passed++;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %0h want 1", out_valid); else passed++;
    total++; if (out_rd !== 5'd1) $display("FAIL addi_rd got %0d want 1", out_rd); else passed++;
    total++; if (out_imm !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL addi_imm got %0h want ffffffffffffffff", out_imm); else passed++;
    total++; if (out_alu_op !== ALU_ADD) $display("FAIL addi_alu got %0d want %0d", out_alu_op, ALU_ADD); else passed++;
    total++; if (out_need_imm !== 1'b1 || out_reg_wen !== 1'b1)
      $display("FAIL addi_flags got need_imm=%0h reg_wen=%0h want 1 1", out_need_imm, out_reg_wen);
    else passed++;
    total++; if (out_pc !== 64'h80000000) $display("FAIL addi_pc got %0h want 80000000", out_pc); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL addi_drain got %0h want 0", out_valid); else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_inst = enc_addi(5'(k), 12'(k)); in_pc = 64'h2000 + 64'(4 * k); in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_accept_%0d got in_ready=%0h want 1", k, in_ready); else passed++;
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full got in_ready=%0h want 0", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_pc !== 64'h2004)
      $display("FAIL bp_held got valid=%0h rd=%0d pc=%0h want 1 1 2004", out_valid, out_rd, out_pc);
    else passed++;
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      total++; if (out_valid !== 1'b1 || out_rd !== 5'(k) || out_imm !== 64'(k))
        $display("FAIL bp_order_%0d got valid=%0h rd=%0d imm=%0h want 1 %0d %0d", k, out_valid, out_rd, out_imm, k, k);
      else passed++;
      step();
    end
    total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %0h want 0", out_valid); else passed++;
  endtask

  task automatic test_decode_classes();
    issue(32'hFE208EE3);
    total++; if (out_is_branch !== 1'b1 || out_imm !== 64'hFFFFFFFFFFFFFFFC || out_br_cond !== 3'd0 || out_reg_wen !== 1'b0)
      $display("FAIL beq got br=%0h imm=%0h cond=%0d wen=%0h want 1 fffffffffffffffc 0 0", out_is_branch, out_imm, out_br_cond, out_reg_wen);
    else passed++;
    issue(32'h008000EF);
    total++; if (out_is_jal !== 1'b1 || out_imm !== 64'd8 || out_reg_wen !== 1'b1 || out_rd !== 5'd1)
      $display("FAIL jal got jal=%0h imm=%0h wen=%0h rd=%0d want 1 8 1 1", out_is_jal, out_imm, out_reg_wen, out_rd);
    else passed++;
    issue(32'h800002B7);
    total++; if (out_is_lui !== 1'b1 || out_imm !== 64'hFFFFFFFF80000000 || out_alu_op !== ALU_PASSB)
      $display("FAIL lui got lui=%0h imm=%0h alu=%0d want 1 ffffffff80000000 %0d", out_is_lui, out_imm, out_alu_op, ALU_PASSB);
    else passed++;
    issue(32'h402081B3);
    total++; if (out_alu_op !== ALU_SUB || out_need_imm !== 1'b0 || out_imm !== 64'd0 || out_rs2 !== 5'd2 || out_illegal !== 1'b0)
      $display("FAIL sub got alu=%0d need_imm=%0h imm=%0h rs2=%0d ill=%0h want %0d 0 0 2 0", out_alu_op, out_need_imm, out_imm, out_rs2, out_illegal, ALU_SUB);
    else passed++;
    issue(32'h43F0D093);
    total++; if (out_alu_op !== ALU_SRA || out_illegal !== 1'b0 || out_need_imm !== 1'b1)
      $display("FAIL srai got alu=%0d ill=%0h need_imm=%0h want %0d 0 1", out_alu_op, out_illegal, out_need_imm, ALU_SRA);
    else passed++;
    issue(32'h00100013);
    total++; if (out_reg_wen !== 1'b0 || out_alu_op !== ALU_ADD || out_illegal !== 1'b0)
      $display("FAIL addi_x0 got wen=%0h alu=%0d ill=%0h want 0 %0d 0", out_reg_wen, out_alu_op, out_illegal, ALU_ADD);
    else passed++;
    step();
  endtask

  task automatic test_stores_loads();
    logic [7:0] masks [4];
    masks[0] = 8'h01; masks[1] = 8'h03; masks[2] = 8'h0F; masks[3] = 8'hFF;
    for (int f = 0; f < 4; f++) begin
      issue(enc_store(3'(f)));
      total++; if (out_wmask !== masks[f] || out_mem_wen !== 1'b1 || out_reg_wen !== 1'b0 || out_imm !== 64'd4)
        $display("FAIL store_%0d got wmask=%0h wen=%0h rwen=%0h imm=%0h want %0h 1 0 4", f, out_wmask, out_mem_wen, out_reg_wen, out_imm, masks[f]);
      else passed++;
    end
    issue({12'd8, 5'd1, 3'b110, 5'd3, 7'b0000011});
    total++; if (out_mem_ren !== 1'b1 || out_mem_unsigned !== 1'b1 || out_reg_wen !== 1'b1 || out_wmask !== 8'h00 || out_imm !== 64'd8)
      $display("FAIL lwu got ren=%0h uns=%0h wen=%0h wmask=%0h imm=%0h want 1 1 1 0 8", out_mem_ren, out_mem_unsigned, out_reg_wen, out_wmask, out_imm);
    else passed++;
    issue({12'd0, 5'd1, 3'b111, 5'd3, 7'b0000011});
    total++; if (out_illegal !== 1'b1 || out_mem_ren !== 1'b0 || out_reg_wen !== 1'b0)
      $display("FAIL load111 got ill=%0h ren=%0h wen=%0h want 1 0 0", out_illegal, out_mem_ren, out_reg_wen);
    else passed++;
    step();
    total++; if (halted !== 1'b1) $display("FAIL illegal_halts got %0h want 1", halted); else passed++;
    do_reset();
  endtask

  task automatic test_nop_illegal();
    issue(32'h00000000);
    total++; if (out_valid !== 1'b1 || out_illegal !== 1'b0 || out_reg_wen !== 1'b0 || out_mem_ren !== 1'b0 ||
                 out_mem_wen !== 1'b0 || out_need_imm !== 1'b0 || out_is_ebreak !== 1'b0 || out_is_branch !== 1'b0)
      $display("FAIL nop got valid=%0h ill=%0h wen=%0h ren=%0h mwen=%0h imm_sel=%0h want 1 0 0 0 0 0", out_valid, out_illegal, out_reg_wen, out_mem_ren, out_mem_wen, out_need_imm);
    else passed++;
    issue(32'h0000707F);
    total++; if (out_illegal !== 1'b1 || out_reg_wen !== 1'b0)
      $display("FAIL op7f got ill=%0h wen=%0h want 1 0", out_illegal, out_reg_wen);
    else passed++;
    do_reset();
  endtask

  task automatic test_ebreak();
    out_ready = 1'b0;
    in_inst = INST_EBREAK; in_valid = 1'b1;
    step();
    in_inst = enc_addi(5'd7, 12'd1);
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_is_ebreak !== 1'b1 || halted !== 1'b0)
      $display("FAIL ebreak_bundle got valid=%0h ebreak=%0h halted=%0h want 1 1 0", out_valid, out_is_ebreak, halted);
    else passed++;
    out_ready = 1'b1;
    step();
    total++; if (halted !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL ebreak_halt got halted=%0h valid=%0h in_ready=%0h want 1 0 0", halted, out_valid, in_ready);
    else passed++;
    step(); step();
    total++; if (out_valid !== 1'b0) $display("FAIL halt_no_addi got valid=%0h rd=%0d want 0", out_valid, out_rd); else passed++;
    do_reset();
    #1;
    total++; if (halted !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL halt_reset got halted=%0h in_ready=%0h want 0 1", halted, in_ready);
    else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_inst = enc_addi(5'(k), 12'(k)); in_valid = 1'b1;
      step();
    end
    in_inst = enc_addi(5'd9, 12'd9); flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0h want 0", in_ready); else passed++;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || halted !== 1'b0)
      $display("FAIL flush_clear got valid=%0h halted=%0h want 0 0", out_valid, halted);
    else passed++;
    out_ready = 1'b1;
    step(); step();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_queue_empty got valid=%0h rd=%0d want 0", out_valid, out_rd); else passed++;
    out_ready = 1'b0;
    for (int k = 10; k <= 14; k++) begin
      in_inst = enc_addi(5'(k), 12'(k)); in_valid = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL flush_refill_%0d got in_ready=%0h want 1", k, in_ready); else passed++;
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd10 || in_ready !== 1'b0)
      $display("FAIL flush_refill_head got valid=%0h rd=%0d in_ready=%0h want 1 10 0", out_valid, out_rd, in_ready);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_backpressure();
    test_decode_classes();
    test_stores_loads();
    test_nop_illegal();
    test_ebreak();
    test_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/idu_stage.md
Name: idu_stage

Overview:
- Registered instruction-decode stage for the RV64 core; successor to the purely combinational decoder.
- Accepts fetched instructions through a valid/ready port and buffers them in a parametrised-depth instruction queue.
- Decodes the head entry into a pipeline register with a valid/ready output port, covering the full RV64I base integer set.
- Contains a run/halt state machine that stops intake after an ebreak or illegal instruction leaves the stage.

Parameters:
XLEN, 64, datapath/immediate width; immediates sign-extended to XLEN
PC_W, 64, program-counter width
IQ_DEPTH, 4, instruction-queue entries; power of two, at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard queue and output register (redirect)
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage accepts instruction
in_inst  in  32  instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  PC_W  pc of decoded instruction
out_rd / out_rs1 / out_rs2  out  5 each  register indices (raw fields)
out_imm  out  XLEN  selected immediate (I/S/B/U/J), 0 for R-type
out_alu_op  out  4  ALU operation, encoding from package
out_need_imm  out  1  ALU operand 2 is immediate
out_reg_wen  out  1  writes rd (forced 0 when rd==0)
out_mem_ren / out_mem_wen  out  1 each  load / store
out_mem_unsigned  out  1  zero-extend load
out_wmask  out  8  byte mask: sb 0x01, sh 0x03, sw 0x0F, sd 0xFF, else 0x00
out_is_jal / out_is_jalr / out_is_branch / out_is_auipc / out_is_lui / out_is_ebreak  out  1 each  class flags
out_br_cond  out  3  funct3 of branch
out_illegal  out  1  instruction not implemented
halted  out  1  state machine in HALT

Behaviour:
- Reset (clk edge with rst=1): queue empty, pointers and count = 0, out_valid=0, all out_* bundle fields = 0, state=RUN, halted=0. Reset mid-transfer discards everything.
- in_ready = (count != IQ_DEPTH) && state==RUN && !flush. Push when in_valid && in_ready.
- Output register loads the decoded queue head when head exists && (!out_valid || out_ready); the head is popped in the same cycle.
- Push and pop in the same cycle: count unchanged; legal at any non-full occupancy.
- Pointers wrap modulo IQ_DEPTH. Count width is clog2(IQ_DEPTH+1).
- Latency: instruction accepted at edge E0 gives out_valid=1 after edge E1 (queue empty, out_ready=1). Sustained throughput is 1 per cycle.
- out_valid held with out_ready=0: bundle is stable; queue keeps filling until full.
- flush: queue emptied and out_valid=0 at the next edge; flush has priority over push/pop; state unchanged.
- State machine RUN -> HALT when a bundle with out_is_ebreak or out_illegal completes its handshake (out_valid && out_ready). In HALT: in_ready=0, no further loads into the output register, halted=1. Only rst returns to RUN.
- Decode coverage:
  - LUI, AUIPC, JAL, JALR (funct3 must be 000).
  - Branches with funct3 000/001/100/101/110/111; 010/011 are illegal.
  - Loads LB/LH/LW/LD/LBU/LHU/LWU; 111 is illegal.
  - Stores SB/SH/SW/SD; funct3 1xx is illegal.
  - OP-IMM, including SLLI/SRLI/SRAI with 6-bit shamt; funct7[6:1] must be 000000, or 010000 for SRAI.
  - OP: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
  - EBREAK (inst == 32'h00100073).
  - All-zero word decodes as legal NOP: every enable and flag 0.
  - Anything else is illegal: out_illegal=1, all enables 0.
- Immediates use bit 31 as sign, extended to XLEN. B and J immediates have LSB 0.
- alu_op: add for loads/stores/jalr/auipc/addi; lui passes the immediate.

Decomposition:
- Shared package idu_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM)
  - alu_op encoding: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB
  - wmask constants and the state enum RUN/HALT
- One natural sub-module: idu_decode_comb, the purely combinational instruction-to-bundle decoder. The queue and state machine live in idu_stage.

Test Plan:
- Reset, then push addi x1,x0,-1 (0xFFF00093) at pc 0x80000000 → two edges later: out_valid=1, out_rd=1, out_imm=0xFFFFFFFFFFFFFFFF, alu_op=ADD, need_imm=1, reg_wen=1.
- out_ready=0 while pushing 5 instructions, IQ_DEPTH=4 → in_ready drops after the 4th acceptance beyond the held bundle; then out_ready=1 → all bundles emerge in order, one per cycle.
- sb/sh/sw/sd stream → wmask 0x01/0x03/0x0F/0xFF with mem_wen=1, reg_wen=0; lwu → mem_ren=1, mem_unsigned=1; funct3 111 load → out_illegal=1.
- ebreak followed by addi → ebreak bundle handshakes, halted=1 next cycle, in_ready=0, addi never appears; rst → halted=0.
- Queue holding 3 entries, flush=1 together with in_valid=1 → next cycle out_valid=0, count=0, pushed instruction dropped.
- 0x00000000 → legal NOP, no enables set; 0x0000707F → out_illegal=1.
